// File: rtl/pipeline_flow_ctrl.sv
// Stall/flush/halt sequencer for the five-stage pipeline: stage enables, bubble injection,
// SYSCALL halt with GO-released resume, and saturating performance counters.
module pipeline_flow_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             r1_used,
  input  logic             r2_used,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             regwrite_ex,
  input  logic [4:0]       wbreg_ex,
  input  logic             regwrite_mem,
  input  logic [4:0]       wbreg_mem,
  input  logic             jump_id,
  input  logic             branch_ex,
  input  logic             syscall_halt,
  input  logic             GO,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e     state_q, state_d;
  logic       go_q;
  logic       resume_q, resume_d;
  logic       haz, haz_rs, haz_rt;
  logic       halt_req;
  logic       cycle_inc, stall_inc, flush_inc;

  // Register 0 is hardwired, so a read of it never depends on an in-flight writer.
  assign haz_rs = r1_used && (rs != 5'd0) &&
                  ((regwrite_ex && (wbreg_ex == rs)) || (regwrite_mem && (wbreg_mem == rs)));
  assign haz_rt = r2_used && (rt != 5'd0) &&
                  ((regwrite_ex && (wbreg_ex == rt)) || (regwrite_mem && (wbreg_mem == rt)));
  assign haz    = haz_rs || haz_rt;

  // The resume cycle lets the frozen SYSCALL retire instead of halting again.
  assign halt_req = syscall_halt && !resume_q;

  always_comb begin
    state_d     = state_q;
    resume_d    = 1'b0;
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    bubble_ifid = 1'b0;
    bubble_idex = 1'b0;
    halt        = 1'b0;
    cycle_inc   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (state_q == StHalt || halt_req) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
      halt     = 1'b1;
      if (state_q == StHalt) begin
        if (GO && !go_q) begin
          state_d  = StRun;
          resume_d = 1'b1;
        end
      end else begin
        state_d = StHalt;
      end
    end else begin
      cycle_inc = 1'b1;
      if (branch_ex) begin
        bubble_ifid = 1'b1;
        bubble_idex = 1'b1;
        flush_inc   = 1'b1;
      end else if (haz) begin
        pc_en       = 1'b0;
        en_ifid     = 1'b0;
        bubble_idex = 1'b1;
        stall_inc   = 1'b1;
      end else if (jump_id) begin
        bubble_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q  <= StRun;
      go_q     <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      go_q     <= GO;
      resume_q <= resume_d;
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cycle_inc && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Bench for pipeline_flow_ctrl: a 32-bit and a 4-bit counter instance share stimulus and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_pipeline_flow_ctrl;

  logic       clk = 1'b0;
  logic       CLR = 1'b0;
  logic       r1_used = 0, r2_used = 0;
  logic [4:0] rs = 0, rt = 0;
  logic       regwrite_ex = 0, regwrite_mem = 0;
  logic [4:0] wbreg_ex = 0, wbreg_mem = 0;
  logic       jump_id = 0, branch_ex = 0, syscall_halt = 0, GO = 0;

  logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_ifid, bubble_idex, halt;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic        s_pc_en, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
  logic        s_bubble_ifid, s_bubble_idex, s_halt;
  logic [3:0]  s_cycle_cnt, s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_flow_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .CLR(CLR), .r1_used(r1_used), .r2_used(r2_used), .rs(rs), .rt(rt),
    .regwrite_ex(regwrite_ex), .wbreg_ex(wbreg_ex), .regwrite_mem(regwrite_mem),
    .wbreg_mem(wbreg_mem), .jump_id(jump_id), .branch_ex(branch_ex),
    .syscall_halt(syscall_halt), .GO(GO), .pc_en(pc_en), .en_ifid(en_ifid),
    .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb), .bubble_ifid(bubble_ifid),
    .bubble_idex(bubble_idex), .halt(halt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipeline_flow_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .CLR(CLR), .r1_used(r1_used), .r2_used(r2_used), .rs(rs), .rt(rt),
    .regwrite_ex(regwrite_ex), .wbreg_ex(wbreg_ex), .regwrite_mem(regwrite_mem),
    .wbreg_mem(wbreg_mem), .jump_id(jump_id), .branch_ex(branch_ex),
    .syscall_halt(syscall_halt), .GO(GO), .pc_en(s_pc_en), .en_ifid(s_en_ifid),
    .en_idex(s_en_idex), .en_exmem(s_en_exmem), .en_memwb(s_en_memwb),
    .bubble_ifid(s_bubble_ifid), .bubble_idex(s_bubble_idex), .halt(s_halt),
    .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_halted, m_go, m_resume;
  longint m_cyc, m_stl, m_fls;       // unbounded event counts
  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit raw_hazard();
    logic [4:0] src [2];
    bit         used[2];
    logic [4:0] dst [2];
    bit         wr  [2];
    src = '{rs, rt};           used = '{r1_used, r2_used};
    dst = '{wbreg_ex, wbreg_mem}; wr = '{regwrite_ex, regwrite_mem};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (used[i] && src[i] != 0 && wr[j] && dst[j] == src[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit halting();
    return m_halted || (syscall_halt && !m_resume);
  endfunction

  // {pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_ifid, bubble_idex, halt}
  function automatic logic [7:0] expected_outs();
    if (halting())         return 8'b00000_00_1;
    else if (branch_ex)    return 8'b11111_11_0;
    else if (raw_hazard()) return 8'b00111_01_0;
    else if (jump_id)      return 8'b11111_10_0;
    else                   return 8'b11111_00_0;
  endfunction

  always @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      m_halted <= 0; m_go <= 0; m_resume <= 0;
      m_cyc <= 0; m_stl <= 0; m_fls <= 0;
    end else begin
      m_go     <= GO;
      m_resume <= m_halted && GO && !m_go;
      m_halted <= halting() && !(m_halted && GO && !m_go);
      if (!halting()) begin
        m_cyc <= m_cyc + 1;
        if (branch_ex) m_fls <= m_fls + 1;
        else if (raw_hazard()) m_stl <= m_stl + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_o;
    exp_o = expected_outs();
    check("outs", {pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_ifid, bubble_idex, halt},
          exp_o);
    check("outs_small", {s_pc_en, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_bubble_ifid,
          s_bubble_idex, s_halt}, exp_o);
    check("cycle_cnt", cycle_cnt, sat(m_cyc, 32));
    check("stall_cnt", stall_cnt, sat(m_stl, 32));
    check("flush_cnt", flush_cnt, sat(m_fls, 32));
    check("cycle_cnt4", s_cycle_cnt, sat(m_cyc, 4));
    check("stall_cnt4", s_stall_cnt, sat(m_stl, 4));
    check("flush_cnt4", s_flush_cnt, sat(m_fls, 4));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r1_used = 0; r2_used = 0; rs = 0; rt = 0; regwrite_ex = 0; regwrite_mem = 0;
    wbreg_ex = 0; wbreg_mem = 0; jump_id = 0; branch_ex = 0; syscall_halt = 0;
  endtask

  initial begin
    logic [31:0] c0;
    int          running;
    idle();
    #12;
    check("rst_outs", {pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_ifid, bubble_idex,
          halt}, 8'b11111_00_0);
    check("rst_cnts", {cycle_cnt, stall_cnt, flush_cnt}, 96'd0);
    next_cycle();
    CLR = 1'b1;
    repeat (10) next_cycle();
    check("cycle10", cycle_cnt, 10);

    // RAW via EX then MEM
    r1_used = 1; rs = 5; regwrite_ex = 1; wbreg_ex = 5;
    @(negedge clk);
    check("raw_ex", {pc_en, en_ifid, bubble_idex, en_idex}, 4'b0011);
    next_cycle();
    regwrite_ex = 0; regwrite_mem = 1; wbreg_mem = 5;
    @(negedge clk);
    check("raw_mem", {pc_en, en_ifid, bubble_idex, en_idex}, 4'b0011);
    next_cycle();
    idle();
    check("stall2", stall_cnt, 2);

    // same pattern on r0: no stall
    r1_used = 1; rs = 0; regwrite_ex = 1; wbreg_ex = 0;
    @(negedge clk);
    check("r0_nostall", {pc_en, bubble_idex}, 2'b10);
    next_cycle();
    // rt hazard through MEM
    idle(); r2_used = 1; rt = 9; regwrite_mem = 1; wbreg_mem = 9;
    next_cycle();
    idle();
    check("stall3", stall_cnt, 3);

    // branch together with hazard
    r1_used = 1; rs = 7; regwrite_ex = 1; wbreg_ex = 7; branch_ex = 1;
    @(negedge clk);
    check("br_haz", {pc_en, bubble_ifid, bubble_idex}, 3'b111);
    next_cycle();
    idle();
    check("br_flush", flush_cnt, 1);
    check("br_stall", stall_cnt, 3);

    // jump alone, then jump with branch
    jump_id = 1;
    @(negedge clk);
    check("jump", {pc_en, en_ifid, en_idex, bubble_ifid, bubble_idex}, 5'b11110);
    next_cycle();
    branch_ex = 1;
    @(negedge clk);
    check("jump_br", {bubble_ifid, bubble_idex}, 2'b11);
    next_cycle();
    idle();

    // halt and resume
    c0 = cycle_cnt;
    syscall_halt = 1;
    @(negedge clk);
    check("halt_now", {halt, pc_en, en_memwb}, 3'b100);
    repeat (4) next_cycle();
    check("cyc_frozen", cycle_cnt, c0);
    GO = 1;
    running = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!halt) running++;
      if (i == 1) check("resume_nohalt", halt, 0);
      next_cycle();
    end
    check("one_resume", running, 1);
    check("cyc_resume", cycle_cnt, c0 + 1);
    GO = 0; syscall_halt = 0;
    next_cycle();
    check("still_halted", halt, 1);
    GO = 1;
    next_cycle();
    GO = 0;
    @(negedge clk);
    check("resumed", halt, 0);
    repeat (3) next_cycle();

    // small counter saturated; async clear in mid-cycle
    check("sat15", s_cycle_cnt, 15);
    next_cycle();
    check("sat_hold", s_cycle_cnt, 15);
    #1;
    CLR = 0;
    #1;
    check("aclr", {cycle_cnt, stall_cnt, flush_cnt}, 96'd0);
    check("aclr4", {s_cycle_cnt, s_stall_cnt, s_flush_cnt}, 12'd0);
    next_cycle();
    CLR = 1;
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_ctrl.md
# pipeline_flow_ctrl

Central stall/flush/halt sequencer for the five-stage pipeline: it replaces the scattered `!halt` enable logic and the bubble generation. It sits beside the control unit and drives the PC enable, the IF/ID and ID/EX enables and bubble inputs, and the global halt. It also exposes performance counters for the display path. It detects RAW data hazards against the EX and MEM stages, flushes on taken branches and jumps, and runs a SYSCALL halt/resume state machine released by `GO`.

## Interface
- `CNT_W`, 32, width of each performance counter
- `clk` input 1: pipeline clock, rising edge
- `CLR` input 1: asynchronous, active-low reset
- `r1_used`, `r2_used` input 1 each: ID-stage instruction reads rs / rt
- `rs`, `rt` input 5 each: ID-stage source register numbers
- `regwrite_ex`, `wbreg_ex` input 1 / 5: EX-stage writer flag and destination
- `regwrite_mem`, `wbreg_mem` input 1 / 5: MEM-stage writer flag and destination
- `jump_id` input 1: JMP, JR or JAL decoded in ID
- `branch_ex` input 1: branch taken, resolved in EX
- `syscall_halt` input 1: halting SYSCALL present in WB (already qualified)
- `GO` input 1: resume button, level; rising edge is used
- `pc_en`, `en_ifid`, `en_idex`, `en_exmem`, `en_memwb` output 1 each: stage register enables
- `bubble_ifid`, `bubble_idex` output 1 each: load NOP into that pipeline register
- `halt` output 1: pipeline frozen
- `cycle_cnt`, `stall_cnt`, `flush_cnt` output CNT_W each: performance counters

## Operation
- **States:** RUN and HALT. Reset state is RUN.
- **Registers:**
  - `go_q`, sampling GO each cycle.
  - `resume`, set for exactly the first cycle in RUN after HALT.
- **Data hazard:** `haz` = (r1_used & rs≠0 & ((regwrite_ex & wbreg_ex==rs) | (regwrite_mem & wbreg_mem==rs))), ORed with the same term for r2_used/rt.
- **halt_req:** syscall_halt & ~resume. The resume cycle ignores syscall_halt so the frozen SYSCALL can retire.
- **Priority:** halt_req/HALT > branch_ex > haz > jump_id.
- **HALT or halt_req:**
  - All enables 0, bubbles 0, `halt`=1.
  - halt_req in RUN moves to HALT next cycle.
- **branch_ex:**
  - All enables 1.
  - bubble_ifid=1 and bubble_idex=1, squashing the two younger instructions.
  - `flush_cnt`+1.
- **haz:**
  - pc_en=0, en_ifid=0; en_idex, en_exmem, en_memwb=1.
  - bubble_idex=1, bubble_ifid=0.
  - `stall_cnt`+1.
- **jump_id:** all enables 1, bubble_ifid=1, bubble_idex=0.
- **Otherwise:** all enables 1, bubbles 0.
- **Leaving HALT:** GO & ~go_q moves to RUN next cycle and sets `resume`. GO held high does not retrigger.
- **cycle_cnt:** increments every cycle the state is RUN and halt_req=0.
- **Counter width:** all counters are CNT_W wide and saturate at all-ones. There is no wrap.

## Timing
- All enable, bubble and halt outputs are combinational (Mealy) from the inputs and the registered state. They are valid before the same clock edge that consumes them.
- State, `go_q`, `resume` and the counters update on the rising clk edge. Counter outputs are registered, so a counted event is visible one cycle later.
- **Reset (CLR=0, asynchronous):**
  - state RUN, go_q 0, resume 0, all counters 0.
  - Outputs follow the RUN equations. With all inputs 0: pc_en and all en_* = 1, bubbles 0, halt 0.
- Reset asserted while in HALT returns to RUN immediately. Counters clear.
- **Halt latency:** `halt` rises in the same cycle syscall_halt is seen. Resume occurs one cycle after the GO rising edge is sampled.
- **Data stalls:** a haz stall lasts as long as the writer occupies EX or MEM, so at most 2 cycles per hazard with no forwarding.
- **Simultaneous events:**
  - branch_ex with haz: the branch wins. The stalled ID instruction is squashed, and stall_cnt is not incremented.
  - branch_ex with jump_id: branch behaviour applies.

## Test plan
- **Reset:** reset, then release with idle inputs. Expect pc_en and all en_* = 1, bubbles 0, halt 0, all counters 0. Expect cycle_cnt = 10 after 10 cycles.
- **RAW stall:**
  - Stimulus: rs=5, r1_used=1, regwrite_ex=1, wbreg_ex=5 for 1 cycle; then regwrite_mem=1, wbreg_mem=5 for 1 cycle.
  - Expect pc_en=0, en_ifid=0, bubble_idex=1 for both cycles, and stall_cnt=2.
  - Repeat with rs=0: no stall.
- **Branch + hazard:** branch_ex=1 together with an active hazard. Expect bubble_ifid=1, bubble_idex=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
- **Jump:** jump_id=1 alone. Expect bubble_ifid=1, bubble_idex=0, all enables 1.
- **Halt/resume:**
  - syscall_halt=1 held: halt=1 the same cycle, all enables 0; cycle_cnt frozen while halted.
  - GO held high for 5 cycles: exactly one resume. The resume cycle has halt=0 despite syscall_halt=1.
  - The next cycle with syscall_halt=1 halts again.
- **Counter saturation:** CNT_W=4, run 20 idle cycles. Expect cycle_cnt=15 and held. Then assert CLR mid-run: expect all counters 0 asynchronously.
